// File: rtl/seg_text_scroller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : seg_text_scroller
// Brief  : ASCII message buffer that scrolls right-to-left through a
//          four-character seven-segment window. Define SEG_SCROLL_LOOP_EN
//          for endless looping; otherwise a single pass ends in DONE.
// Rev    : 1.0  initial release
// ============================================================================
module seg_text_scroller #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       commit,
    input  logic       clear,
    output logic [7:0] display_0,
    output logic [7:0] display_1,
    output logic [7:0] display_2,
    output logic [7:0] display_3,
    output logic [1:0] decplace,
    output logic       done
);

    localparam int              TW          = $clog2(TICK_DIV);
    localparam logic [AW:0]     c_depth     = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]   c_tick_last = TW'(TICK_DIV - 1);
    localparam logic [7:0]      c_blank     = 8'h20;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SCROLL = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW:0]     r_len;
    logic [AW:0]     r_pos;
    logic [TW-1:0]   r_tick;
    logic [7:0]      r_buf [DEPTH];
    logic [7:0]      r_disp [4];
    logic            r_done;

    logic            w_wr_acc;
    logic [AW:0]     w_len_post;
    logic            w_tick;
    logic            w_end;
    logic [AW+1:0]   w_vlen;
    logic [7:0]      w_win [4];

    assign wr_ready   = (r_state == S_LOAD) && (r_len < c_depth);
    assign w_wr_acc   = wr_valid && wr_ready && !clear;
    assign w_len_post = r_len + {{AW{1'b0}}, w_wr_acc};
    assign w_tick     = (r_tick == c_tick_last);
    assign w_vlen     = {1'b0, r_len} + (AW+2)'(4);

`ifdef SEG_SCROLL_LOOP_EN
    // Last virtual position; the scroll wraps back to the start after it.
    assign w_end = ({1'b0, r_pos} == (w_vlen - (AW+2)'(1)));
`else
    // Window is entirely trailing blanks once pos reaches len.
    assign w_end = (r_pos == r_len);
`endif

    // Message storage is deliberately left unreset; len bounds what is visible.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_buf[r_len[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_LOAD;
            r_len   <= '0;
            r_pos   <= '0;
            r_tick  <= '0;
        end else if (clear) begin
            r_state <= S_LOAD;
            r_len   <= '0;
            r_pos   <= '0;
            r_tick  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_len <= w_len_post;
                    if (commit && (w_len_post != '0)) begin
                        r_state <= S_SCROLL;
                        r_pos   <= '0;
                        r_tick  <= '0;
                    end
                end
                S_SCROLL: begin
                    if (w_tick) begin
                        r_tick <= '0;
`ifdef SEG_SCROLL_LOOP_EN
                        r_pos  <= w_end ? '0 : r_pos + 1'b1;
`else
                        if (w_end) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                        end
`endif
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_DONE: begin
                    if (commit) begin
                        r_state <= S_SCROLL;
                        r_pos   <= '0;
                        r_tick  <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Window character k is the virtual message at (pos + k) mod (len + 4).
    for (genvar k = 0; k < 4; k++) begin : g_win
        logic [AW+1:0] w_sum;
        logic [AW+1:0] w_idx;
        assign w_sum    = {1'b0, r_pos} + (AW+2)'(k);
        assign w_idx    = (w_sum >= w_vlen) ? (w_sum - w_vlen) : w_sum;
        assign w_win[k] = (w_idx < {1'b0, r_len}) ? r_buf[w_idx[AW-1:0]] : c_blank;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= c_blank;
            end
            r_done <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= (r_state == S_SCROLL) ? w_win[i] : c_blank;
            end
            r_done <= (r_state == S_DONE);
        end
    end

    assign display_0 = r_disp[0];
    assign display_1 = r_disp[1];
    assign display_2 = r_disp[2];
    assign display_3 = r_disp[3];
    assign done      = r_done;
    assign decplace  = 2'b00;

endmodule
`default_nettype wire

// File: doc/seg_text_scroller.md
# seg_text_scroller

Message buffer and scroll sequencer that feeds the four-digit seven-segment driver. It accepts ASCII characters over a valid/ready write port and stores them in a small buffer. On commit, it scrolls the stored message right-to-left through a four-character window. It drives the driver's `display_0`..`display_3` (ASCII; `display_0` = leftmost digit) and `decplace` inputs directly.

## Interface
- `DEPTH`, 16, message buffer capacity in characters; power of two, ≥4.
- `AW`, 4, buffer address width; must equal log2(DEPTH).
- `TICK_DIV`, 25_000_000, clk cycles per scroll step; ≥2.

- `clk`  in  1  system clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  character write request.
- `wr_data`  in  8  ASCII character; any value is stored unchanged.
- `wr_ready`  out  1  buffer accepts a character this cycle.
- `commit`  in  1  single-cycle pulse: start or replay the scroll.
- `clear`  in  1  single-cycle pulse: empty the buffer and return to LOAD.
- `display_0`..`display_3`  out  8 each  window characters, registered; `display_0` is leftmost.
- `decplace`  out  2  decimal-point select; constant 2'b00 (reserved).
- `done`  out  1  registered; high in DONE.

## Operation
- States: LOAD, SCROLL, DONE. Reset state is LOAD.
- Reset values:
  - `len` = 0, `pos` = 0, tick counter = 0.
  - All `display_*` = 8'h20.
  - `done` = 0, `decplace` = 0.
  - `wr_ready` = 1 (combinational from reset state).
- `wr_ready` = (state == LOAD) && (`len` < DEPTH). `len` is AW+1 bits wide.
- Write accept: `wr_valid` && `wr_ready` at a clock edge. Effect: `buf[len]` ← `wr_data`, `len`++.
- LOAD:
  - Displays are all 8'h20.
  - `commit` goes to SCROLL when the post-write `len` is nonzero; otherwise `commit` is ignored.
- Virtual message: index `v` in 0..L-1, where L = `len` + 4. `char(v)` = `buf[v]` if `v` < `len`, else 8'h20.
- SCROLL:
  - `display_k` = `char((pos + k) mod L)` for k = 0..3.
  - Each tick advances `pos`.
  - Writes are refused. `commit` is ignored.
- DONE:
  - Displays are all 8'h20 and `done` = 1.
  - `commit` → SCROLL with `pos` = 0; the message is retained.
  - Writes are refused.
- `clear`, from any state: → LOAD, `len` = 0, `pos` = 0, tick counter = 0, `done` = 0, displays 8'h20.
- Priority within one cycle: `clear` > write > `commit`.
  - A write and a `commit` in the same cycle: the written character is part of the message.
  - `clear` with a write: the write is not accepted. `wr_ready` still reads 1 combinationally in LOAD.
- Buffer contents are not reset; only `len` is. Stale bytes at or beyond `len` are never displayed.

## Timing
- Tick counter:
  - Runs only in SCROLL and is zeroed on every entry to SCROLL.
  - A tick fires when the counter equals TICK_DIV-1; the counter then wraps to 0.
- `commit` accepted at edge N: the displays show `pos` = 0 after edge N+1 (1-cycle latency).
- First advance is TICK_DIV cycles after SCROLL entry. The display update follows each tick by one cycle.
- `done` rises on the same edge the displays blank.
- `clear` takes effect at the next edge. Outputs show LOAD values one cycle later.

## Configuration
- `SEG_SCROLL_LOOP_EN` defined (loop mode):
  - At a tick with `pos` = L-1, `pos` wraps to 0 and the scroll repeats indefinitely.
  - DONE is unreachable and `done` stays 0.
- `SEG_SCROLL_LOOP_EN` undefined (one-pass mode):
  - At a tick with `pos` == `len` (window fully blank), go to DONE.
  - Otherwise `pos`++.

## Test plan
All scenarios use TICK_DIV = 4 and DEPTH = 16.
- Reset: pulse `rstn` low mid-scroll → displays 20 20 20 20, `wr_ready` = 1, `done` = 0, `decplace` = 0.
- Basic scroll: write "HELLO" (48 45 4C 4C 4F), then `commit` →
  - +1 cycle: 48 45 4C 4C.
  - +5 cycles: 45 4C 4C 4F.
  - +9 cycles: 4C 4C 4F 20.
- Full buffer: 16 consecutive writes → `wr_ready` = 0 after the 16th accept. A 17th `wr_valid` is not accepted and `len` stays 16.
- Commit edge cases:
  - `commit` on an empty buffer → stays in LOAD, displays 20×4.
  - Write 41 with `commit` in the same cycle → SCROLL, displays 41 20 20 20.
- Wrap / end of pass: write "AB", then `commit` (L = 6).
  - With `SEG_SCROLL_LOOP_EN`: after 6 ticks the displays return to 41 42 20 20.
  - Without it: after the 3rd tick `done` = 1 and displays are 20×4. A further `commit` replays from 41 42 20 20.
- Clear mid-scroll: `clear` with `commit` in the same cycle → LOAD, `len` = 0, displays 20×4, `wr_ready` = 1, `done` = 0.
